hsi_vector_stream_driver: RTL and testbench

Host-side driver for the HSI vector core. It sits between a pair-of-vectors source stream and the core's three FIFO ports. It splits each source beat into the core's two input FIFOs and drives `op_code`. It also drains the core's output FIFO into a valid/ready result stream, tags the last result and signals completion of a job of `len` vectors.

---
 rtl/hsi_pkg.sv | 24 ++
 rtl/hsi_result_stage.sv | 40 ++++
 rtl/hsi_vector_stream_driver.sv | 123 ++++++++++++
 tb/tb_hsi_vector_stream_driver.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsi_pkg.sv
// Shared definitions for the HSI vector core and its host-side stream driver.
package hsi_pkg;

  localparam int unsigned OPC_WIDTH       = 2;
  localparam int unsigned COMPONENT_WIDTH = 16;

  localparam logic [OPC_WIDTH-1:0] OP_NOP   = 2'd0;
  localparam logic [OPC_WIDTH-1:0] OP_CROSS = 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drv_state_t;

  // One H/S/I vector as carried on the core FIFO ports.
  typedef struct packed {
    logic [COMPONENT_WIDTH-1:0] h;
    logic [COMPONENT_WIDTH-1:0] s;
    logic [COMPONENT_WIDTH-1:0] i;
  } hsi_vec_t;

endpackage

// File: rtl/hsi_result_stage.sv
// Drains the core output FIFO one entry at a time into a registered
// valid/ready result stream.
module hsi_result_stage #(
  parameter int unsigned DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_en,
  input  logic                  out_empty,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic                  res_ready,
  output logic                  rd_en_c,
  output logic                  capture_c,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data
);

  logic rd_pending_q;

  // Only one read in flight and only into an empty result slot, so nothing is dropped.
  assign rd_en_c   = drain_en && !out_empty && !rd_pending_q && !res_valid;
  assign capture_c = rd_pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
    end else begin
      rd_pending_q <= rd_en_c;
      if (rd_pending_q) begin
        res_data  <= out_data;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hsi_vector_stream_driver.sv
// Host-side driver: feeds vector pairs into the HSI core input FIFOs and
// drains cross-product results into a valid/ready stream for a job of len pairs.
module hsi_vector_stream_driver #(
  parameter int unsigned COMPONENT_WIDTH = 16,
  parameter int unsigned OPC_WIDTH       = 2,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         len,
  output logic                         busy,
  output logic                         done,
  input  logic                         src_valid,
  output logic                         src_ready,
  input  logic [6*COMPONENT_WIDTH-1:0] src_data,
  output logic                         in1_wr_en,
  output logic                         in2_wr_en,
  output logic [3*COMPONENT_WIDTH-1:0] in1_data,
  output logic [3*COMPONENT_WIDTH-1:0] in2_data,
  input  logic                         in1_full,
  input  logic                         in2_full,
  output logic                         out_rd_en,
  input  logic                         out_empty,
  input  logic [3*COMPONENT_WIDTH-1:0] out_data,
  output logic [OPC_WIDTH-1:0]         op_code,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3*COMPONENT_WIDTH-1:0] res_data,
  output logic                         res_last
);

  localparam int unsigned VEC_W = 3 * COMPONENT_WIDTH;
  localparam int unsigned SRC_W = 6 * COMPONENT_WIDTH;

  hsi_pkg::drv_state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] issued_q;
  logic [CNT_WIDTH-1:0] received_q;
  logic                 wr_c;
  logic                 capture_c;
  logic                 last_hs_c;
  logic                 in_run_c;
  logic                 active_c;

  assign in_run_c = (state_q == hsi_pkg::RUN);
  assign active_c = in_run_c || (state_q == hsi_pkg::DRAIN);

  // Issue path: both input FIFOs are written together so v1/v2 stay paired.
  assign src_ready = in_run_c && (issued_q < len_q) && !in1_full && !in2_full;
  assign wr_c      = src_valid && src_ready;
  assign in1_wr_en = wr_c;
  assign in2_wr_en = wr_c;
  assign in1_data  = in_run_c ? src_data[SRC_W-1:VEC_W] : '0;
  assign in2_data  = in_run_c ? src_data[VEC_W-1:0]     : '0;

  assign busy    = active_c;
  assign done    = (state_q == hsi_pkg::DONE);
  assign op_code = active_c ? OPC_WIDTH'(hsi_pkg::OP_CROSS) : OPC_WIDTH'(hsi_pkg::OP_NOP);

  assign res_last  = res_valid && (received_q == len_q);
  assign last_hs_c = res_last && res_ready;

  hsi_result_stage #(
    .DATA_WIDTH (VEC_W)
  ) u_result_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .drain_en  (active_c),
    .out_empty (out_empty),
    .out_data  (out_data),
    .res_ready (res_ready),
    .rd_en_c   (out_rd_en),
    .capture_c (capture_c),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= hsi_pkg::IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Final-result acceptance wins over the RUN->DRAIN move.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      hsi_pkg::IDLE: begin
        if (start) state_d = (len != '0) ? hsi_pkg::RUN : hsi_pkg::DONE;
      end
      hsi_pkg::RUN: begin
        if (last_hs_c)               state_d = hsi_pkg::DONE;
        else if (issued_q == len_q)  state_d = hsi_pkg::DRAIN;
      end
      hsi_pkg::DRAIN: begin
        if (last_hs_c) state_d = hsi_pkg::DONE;
      end
      hsi_pkg::DONE: state_d = hsi_pkg::IDLE;
      default:       state_d = hsi_pkg::IDLE;
    endcase
  end

  // Job length and saturating issue/receive counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
    end else if ((state_q == hsi_pkg::IDLE) && start && (len != '0)) begin
      len_q      <= len;
      issued_q   <= '0;
      received_q <= '0;
    end else begin
      if (wr_c) issued_q <= issued_q + CNT_WIDTH'(1);
      if (capture_c && (received_q != len_q)) received_q <= received_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hsi_vector_stream_driver.sv
// Bench for hsi_vector_stream_driver: behavioural HSI core model plus a
// job-level scoreboard of expected cross products, checked per scenario.
module tb_hsi_vector_stream_driver;

  localparam int unsigned CW = 16;
  localparam int unsigned NW = 16;
  localparam int unsigned VW = 3 * CW;
  localparam int unsigned SW = 6 * CW;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] len = '0;
  logic          busy, done;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [SW-1:0] src_data = '0;
  logic          in1_wr_en, in2_wr_en;
  logic [VW-1:0] in1_data, in2_data;
  logic          in1_full, in2_full;
  logic          out_rd_en;
  logic          out_empty;
  logic [VW-1:0] out_data;
  logic [1:0]    op_code;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [VW-1:0] res_data;
  logic          res_last;

  hsi_vector_stream_driver #(
    .COMPONENT_WIDTH (CW),
    .OPC_WIDTH       (2),
    .CNT_WIDTH       (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .in1_wr_en (in1_wr_en),
    .in2_wr_en (in2_wr_en),
    .in1_data  (in1_data),
    .in2_data  (in2_data),
    .in1_full  (in1_full),
    .in2_full  (in2_full),
    .out_rd_en (out_rd_en),
    .out_empty (out_empty),
    .out_data  (out_data),
    .op_code   (op_code),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_last  (res_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Core model state
  logic [VW-1:0] q1[$];
  logic [VW-1:0] q2[$];
  logic [VW-1:0] oq[$];
  int            core_cnt = 0;
  logic          full1_n = 1'b0, full2_n = 1'b0, empty_n = 1'b1;
  logic          full1_q = 1'b0, full2_q = 1'b0, empty_q = 1'b1;
  logic          rd_fire = 1'b0;
  logic [VW-1:0] rd_nxt = '0;
  logic [VW-1:0] out_data_q = '0;
  logic          force_full1 = 1'b0;

  assign in1_full  = full1_q | force_full1;
  assign in2_full  = full2_q;
  assign out_empty = empty_q;
  assign out_data  = out_data_q;

  // Scoreboard / job-level expectations
  logic [SW-1:0] src_q[$];
  logic [VW-1:0] exp_q[$];
  logic          src_acc = 1'b0;
  int            job_len = 0;
  int            recv_cnt = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  int            phase = 0;  // 0 idle, 1 job active, 2 done pulse due
  logic          hold_prev = 1'b0;
  logic [VW-1:0] held_data = '0;
  int            rr_mode = 0;  // 0 random, 1 stalled, 2 always ready

  function automatic logic [VW-1:0] cross3(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [CW-1:0] ah, as_, ai, bh, bs, bi, x, y, z;
    {ah, as_, ai} = a;
    {bh, bs, bi}  = b;
    x = as_ * bi - ai * bs;
    y = ai * bh - ah * bi;
    z = ah * bs - as_ * bh;
    return {x, y, z};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    return {CW'($urandom), CW'($urandom), CW'($urandom)};
  endfunction

  task automatic monitor_step();
    logic hs;
    logic [VW-1:0] exp_d;
    logic exp_last;
    hs = res_valid && res_ready;
    checks++;
    if (busy !== (phase == 1)) begin
      failures++; $display("FAIL busy got=%0b exp=%0b t=%0t", busy, (phase == 1), $time);
    end
    checks++;
    if (done !== (phase == 2)) begin
      failures++; $display("FAIL done got=%0b exp=%0b t=%0t", done, (phase == 2), $time);
    end
    checks++;
    if (op_code !== ((phase == 1) ? hsi_pkg::OP_CROSS : hsi_pkg::OP_NOP)) begin
      failures++; $display("FAIL op_code got=%0d phase=%0d t=%0t", op_code, phase, $time);
    end
    checks++;
    if (in1_wr_en !== in2_wr_en) begin
      failures++; $display("FAIL wr_pairing in1=%0b in2=%0b t=%0t", in1_wr_en, in2_wr_en, $time);
    end
    if (hold_prev) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== held_data) begin
        failures++; $display("FAIL res_hold got=%0h exp=%0h t=%0t", res_data, held_data, $time);
      end
    end
    if (res_valid) begin
      checks++;
      if (out_rd_en !== 1'b0) begin
        failures++; $display("FAIL rd_while_valid got=%0b exp=0 t=%0t", out_rd_en, $time);
      end
    end
    if (force_full1) begin
      checks++;
      if (src_ready !== 1'b0 || in1_wr_en !== 1'b0) begin
        failures++; $display("FAIL full_throttle ready=%0b wr=%0b exp=0 t=%0t", src_ready, in1_wr_en, $time);
      end
    end
    if (hs) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL extra_result got=%0h exp=none t=%0t", res_data, $time);
      end else begin
        exp_d = exp_q.pop_front();
        if (res_data !== exp_d) begin
          failures++; $display("FAIL res_data idx=%0d got=%0h exp=%0h", recv_cnt, res_data, exp_d);
        end
      end
      exp_last = (recv_cnt == job_len - 1);
      checks++;
      if (res_last !== exp_last) begin
        failures++; $display("FAIL res_last idx=%0d got=%0b exp=%0b", recv_cnt, res_last, exp_last);
      end
      recv_cnt++;
    end
    if (in1_wr_en) wr_cnt++;
    if (done) done_cnt++;
    src_acc   = src_valid && src_ready;
    hold_prev = res_valid && !res_ready;
    held_data = res_data;
    case (phase)
      0: if (start) phase = (len != '0) ? 1 : 2;
      1: if (hs && recv_cnt == job_len) phase = 2;
      default: phase = 0;
    endcase
  endtask

  task automatic core_step();
    if (in1_wr_en) q1.push_back(in1_data);
    if (in2_wr_en) q2.push_back(in2_data);
    if (out_rd_en) begin
      checks++;
      if (oq.size() == 0) begin
        failures++; $display("FAIL rd_on_empty got=1 exp=0 t=%0t", $time);
      end else begin
        rd_nxt  = oq.pop_front();
        rd_fire = 1'b1;
      end
    end
    if (core_cnt > 0) core_cnt--;
    else if (q1.size() > 0 && q2.size() > 0 && oq.size() < OUT_DEPTH) begin
      oq.push_back(cross3(q1.pop_front(), q2.pop_front()));
      core_cnt = 3;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL %s busy got=%0b exp=0", tag, busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL %s done got=%0b exp=0", tag, done); end
    checks++; if (src_ready !== 1'b0) begin failures++; $display("FAIL %s src_ready got=%0b exp=0", tag, src_ready); end
    checks++; if ({in1_wr_en, in2_wr_en} !== 2'b00) begin failures++; $display("FAIL %s wr_en got=%0b exp=0", tag, {in1_wr_en, in2_wr_en}); end
    checks++; if ({in1_data, in2_data} !== '0) begin failures++; $display("FAIL %s in_data got=%0h exp=0", tag, {in1_data, in2_data}); end
    checks++; if (out_rd_en !== 1'b0) begin failures++; $display("FAIL %s out_rd_en got=%0b exp=0", tag, out_rd_en); end
    checks++; if (op_code !== 2'd0)   begin failures++; $display("FAIL %s op_code got=%0d exp=0", tag, op_code); end
    checks++; if (res_valid !== 1'b0 || res_last !== 1'b0) begin failures++; $display("FAIL %s res_valid/last got=%0b%0b exp=00", tag, res_valid, res_last); end
    checks++; if (res_data !== '0)    begin failures++; $display("FAIL %s res_data got=%0h exp=0", tag, res_data); end
  endtask

  int wr_base = 0;
  int done_base = 0;

  task automatic launch_job(input int n, input bit fixed);
    logic [VW-1:0] v1, v2;
    for (int k = 0; k < n; k++) begin
      v1 = fixed ? {16'd1, 16'd0, 16'd0} : rand_vec();
      v2 = fixed ? {16'd0, 16'd1, 16'd0} : rand_vec();
      src_q.push_back({v1, v2});
      exp_q.push_back(cross3(v1, v2));
    end
    job_len   = n;
    recv_cnt  = 0;
    wr_base   = wr_cnt;
    done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; len = NW'(n);
    @(posedge clk); #1;
    start = 1'b0; len = NW'($urandom_range(0, 50));
  endtask

  task automatic finish_job(input int n, input string tag);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done_cnt != done_base) break;
    end
    checks++;
    if (done_cnt == done_base) begin
      failures++; $display("FAIL %s done_timeout got=no_done exp=done", tag);
    end
    checks++;
    if (recv_cnt != n || exp_q.size() != 0) begin
      failures++; $display("FAIL %s result_count got=%0d exp=%0d", tag, recv_cnt, n);
    end
    checks++;
    if (wr_cnt - wr_base != n) begin
      failures++; $display("FAIL %s write_count got=%0d exp=%0d", tag, wr_cnt - wr_base, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 check_zero_outputs("idle");
  endtask

  task automatic test_basic();
    rr_mode = 2;
    launch_job(3, 1'b1);
    finish_job(3, "basic");
    rr_mode = 0;
  endtask

  task automatic test_zero_len();
    wr_base = wr_cnt; done_base = done_cnt; job_len = 0; recv_cnt = 0;
    @(posedge clk); #1 start = 1'b1; len = '0;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (done_cnt - done_base != 1 || wr_cnt != wr_base) begin
      failures++; $display("FAIL zero_len done_pulses=%0d writes=%0d exp=1,0", done_cnt - done_base, wr_cnt - wr_base);
    end
  endtask

  task automatic test_input_full();
    launch_job(8, 1'b0);
    repeat (3) @(posedge clk);
    #1 force_full1 = 1'b1;
    repeat (10) @(posedge clk);
    #1 force_full1 = 1'b0;
    finish_job(8, "input_full");
  endtask

  task automatic test_backpressure();
    rr_mode = 1;
    launch_job(20, 1'b0);
    repeat (50) @(posedge clk);
    #1 rr_mode = 0;
    finish_job(20, "backpressure");
  endtask

  task automatic test_reset_mid_job();
    launch_job(5, 1'b0);
    for (int c = 0; c < 2000 && recv_cnt < 2; c++) @(negedge clk);
    checks++;
    if (recv_cnt < 2) begin
      failures++; $display("FAIL mid_job_progress got=%0d exp=2", recv_cnt);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    src_q.delete(); exp_q.delete(); src_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    launch_job(1, 1'b0);
    finish_job(1, "after_reset");
  endtask

  task automatic test_start_busy();
    launch_job(6, 1'b0);
    for (int c = 0; c < 500 && (wr_cnt - wr_base) < 2; c++) @(negedge clk);
    @(posedge clk); #1 start = 1'b1; len = NW'(3);
    @(posedge clk); #1 start = 1'b0;
    finish_job(6, "start_busy");
    repeat (5) @(posedge clk);
    checks++;
    if (done_cnt - done_base != 1) begin
      failures++; $display("FAIL start_busy done_pulses got=%0d exp=1", done_cnt - done_base);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int j = 0; j < 4; j++) begin
      n = $urandom_range(1, 12);
      launch_job(n, 1'b0);
      finish_job(n, "back_to_back");
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        rd_fire = 1'b0;
        if (!rst_n) begin
          phase = 0; hold_prev = 1'b0; src_acc = 1'b0;
          q1.delete(); q2.delete(); oq.delete(); core_cnt = 0;
        end else begin
          monitor_step();
          core_step();
        end
        full1_n = (q1.size() >= IN_DEPTH);
        full2_n = (q2.size() >= IN_DEPTH);
        empty_n = (oq.size() == 0);
      end
      forever begin
        @(posedge clk);
        full1_q <= full1_n;
        full2_q <= full2_n;
        empty_q <= empty_n;
        if (rd_fire) out_data_q <= rd_nxt;
      end
      forever begin
        @(posedge clk); #1;
        if (src_acc && src_q.size() > 0) void'(src_q.pop_front());
        src_acc = 1'b0;
        if (src_q.size() > 0) begin
          src_data  = src_q[0];
          src_valid = ($urandom_range(0, 3) != 0);
        end else begin
          src_valid = 1'b0;
        end
        res_ready = (rr_mode == 1) ? 1'b0 : (rr_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    join_none

    test_reset();
    test_basic();
    test_zero_len();
    test_input_full();
    test_backpressure();
    test_reset_mid_job();
    test_start_busy();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
